// File: rtl/pl_ctrl_pkg.sv
// Shared types for the pipeline control sequencer.
//   ctrl_state_e : sequencer FSM states (encoding is visible on o_state)
//   ctrl_out_t   : the five register enables and three bubble flushes
//   NOP_INSN     : instruction word a flushed register is loaded with
package pl_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DWAIT    = 2'd1,
        IWAIT    = 2'd2,
        IDISCARD = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic en_pc;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } ctrl_out_t;

    // Everything advances, nothing squashed.
    localparam ctrl_out_t CTRL_RUN   = 8'b11111_000;
    // Held in reset: nothing advances, every register holds a bubble.
    localparam ctrl_out_t CTRL_RST   = 8'b00000_111;
    // Data memory outstanding: only WB moves, and it takes a bubble.
    localparam ctrl_out_t CTRL_DWAIT = 8'b00001_001;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears to 0)
//   i_inc          : add one this cycle unless already all-ones
//   o_cnt          : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges hazard-unit requests (load-use, mispredict) with the data- and
// instruction-memory handshakes into per-stage enables and bubble flushes.
// Enables/flushes are Mealy outputs; state, wait timer and perf counters are
// registered.
//   i_clk, i_reset     : clock, asynchronous active-low reset
//   i_load_use         : ID depends on a load in EX
//   i_mispredict       : branch/jump in EX resolved against prediction
//   i_dmem_req/ack     : MEM-stage access pending / completing
//   i_imem_ack         : fetch at PC returns this cycle
//   o_en_*, o_flush_*  : pipeline register enables and bubble loads
//   o_state            : FSM state (debug)
//   o_bus_err          : one-cycle pulse after a wait timeout
//   o_stall_cnt        : cycles with o_en_pc=0 (saturating)
//   o_flush_cnt        : mispredict flush events (saturating)
module pipeline_ctrl_sequencer
    import pl_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_use,
    input  logic             i_mispredict,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    input  logic             i_imem_ack,
    output logic             o_en_pc,
    output logic             o_en_if_id,
    output logic             o_en_id_ex,
    output logic             o_en_ex_mem,
    output logic             o_en_mem_wb,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_flush_mem_wb,
    output logic [1:0]       o_state,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam bit          TO_EN   = (WAIT_TIMEOUT != 0);
    localparam int          TO_W    = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

    ctrl_state_e     state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    // Which handshake timed out; the flag doubles as a forced ack for the
    // cycle o_bus_err is high, so the abandoned access is not re-waited.
    logic            to_dmem_q, to_dmem_d;
    logic            to_imem_q, to_imem_d;
    logic            dwait, imiss, timeout, flush_evt;
    ctrl_out_t       ctrl, ctrl_out;

    assign dwait = i_dmem_req && !(i_dmem_ack || to_dmem_q);
    assign imiss = !(i_imem_ack || to_imem_q);

    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        flush_evt = 1'b0;

        if (state_q == IDISCARD) begin
            if (dwait) begin
                // Front end is frozen, so a wrong-path word arriving now is
                // simply never latched; only the data wait remains.
                ctrl    = CTRL_DWAIT;
                state_d = imiss ? IDISCARD : DWAIT;
            end else begin
                ctrl.flush_if_id = 1'b1;
                ctrl.en_pc       = !imiss;
                if (i_mispredict) begin
                    ctrl.flush_id_ex = 1'b1;
                    flush_evt        = 1'b1;
                end
                state_d = imiss ? IDISCARD : RUN;
            end
        end else begin
            // RUN, IWAIT, and the ack cycle of DWAIT share one priority chain.
            if (dwait) begin
                ctrl    = CTRL_DWAIT;
                state_d = DWAIT;
            end else if (i_mispredict) begin
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                flush_evt        = 1'b1;
                state_d          = imiss ? IDISCARD : RUN;
            end else if (i_load_use) begin
                ctrl.en_pc       = 1'b0;
                ctrl.en_if_id    = 1'b0;
                ctrl.flush_id_ex = 1'b1;
                state_d          = (state_q == IWAIT && imiss) ? IWAIT : RUN;
            end else if (imiss) begin
                ctrl.en_pc       = 1'b0;
                ctrl.flush_if_id = 1'b1;
                state_d          = IWAIT;
            end else begin
                state_d = RUN;
            end
        end

        // Timeout only fires when the FSM would otherwise keep waiting.
        timeout = TO_EN && (state_q != RUN) && (state_d == state_q) &&
                  (wait_cnt_q == TO_LAST);
        if (timeout) state_d = RUN;
        to_dmem_d = timeout && (state_q == DWAIT);
        to_imem_d = timeout && (state_q != DWAIT);

        if (state_d == RUN || state_d != state_q) wait_cnt_d = '0;
        else                                      wait_cnt_d = wait_cnt_q + 1'b1;

        ctrl_out = i_reset ? ctrl : CTRL_RST;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            to_dmem_q  <= 1'b0;
            to_imem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_dmem_q  <= to_dmem_d;
            to_imem_q  <= to_imem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_inc   (!ctrl_out.en_pc),
        .o_cnt   (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_inc   (flush_evt),
        .o_cnt   (o_flush_cnt)
    );

    assign o_en_pc        = ctrl_out.en_pc;
    assign o_en_if_id     = ctrl_out.en_if_id;
    assign o_en_id_ex     = ctrl_out.en_id_ex;
    assign o_en_ex_mem    = ctrl_out.en_ex_mem;
    assign o_en_mem_wb    = ctrl_out.en_mem_wb;
    assign o_flush_if_id  = ctrl_out.flush_if_id;
    assign o_flush_id_ex  = ctrl_out.flush_id_ex;
    assign o_flush_mem_wb = ctrl_out.flush_mem_wb;
    assign o_state        = state_q;
    assign o_bus_err      = to_dmem_q | to_imem_q;

endmodule
